// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings and helpers for the i2c arbiter
// Contents: requester count, i2c_master IDLE code, arbiter state encoding,
// one-hot to index helper.
package i2c_pkg;

    localparam int NREQ = 4;

    // istate value reported by i2c_master while it sits in IDLE
    localparam logic [3:0] MST_IDLE = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_XFER   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - arbiter to i2c_master connection
// Signals: m_enable/m_rw/m_da/m_rep/m_bytcount/m_addr/m_din toward the master,
// m_dout/m_istate back from it.
// Modports: master = arbiter side, slave = i2c_master side.
interface i2c_arbiter_if;
    logic        m_enable;
    logic        m_rw;
    logic        m_da;
    logic        m_rep;
    logic [1:0]  m_bytcount;
    logic [6:0]  m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout;
    logic [3:0]  m_istate;

    modport master (
        output m_enable, m_rw, m_da, m_rep, m_bytcount, m_addr, m_din,
        input  m_dout, m_istate
    );

    modport slave (
        input  m_enable, m_rw, m_da, m_rep, m_bytcount, m_addr, m_din,
        output m_dout, m_istate
    );
endinterface

// File: rtl/i2c_arbiter_rr_pick4.sv
// rtl/i2c_arbiter_rr_pick4.sv - combinational 4-way round-robin winner pick
// Ports: req[3:0] requests, ptr[1:0] last winner, gnt[3:0] one-hot winner
// (all zero when no request is pending).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic [1:0] idx;
    logic       found;

    // Search ptr+1, ptr+2, ptr+3, ptr; 2-bit addition wraps 3->0.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c_master among 4 requesters
// Ports: clk, rst (async active-low); req/req_rw/req_da/req_rep per requester,
// req_bytcount/req_addr/req_din packed per requester; gnt one-hot grant,
// done one-cycle completion pulse, err start timeout flag, rdata captured read
// data, busy; bus = i2c_master connection.
module i2c_arbiter #(
    parameter int START_TO = 16,
    parameter int NREQ     = i2c_pkg::NREQ
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [NREQ-1:0]      req_da,
    input  logic [NREQ-1:0]      req_rep,
    input  logic [2*NREQ-1:0]    req_bytcount,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic                 busy,
    i2c_arbiter_if.master        bus
);

    import i2c_pkg::*;

    localparam int CW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TO - 1);

    state_t        state, state_next;
    logic [3:0]    pick;
    logic [1:0]    pick_idx;
    logic [1:0]    win;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic          err_r;

    // Strobes from the next-state logic into the datapath registers
    logic do_latch, do_inc, do_started, do_timeout, do_capture, do_finish;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    assign pick_idx = onehot_idx(pick);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_latch   = 1'b0;
        do_inc     = 1'b0;
        do_started = 1'b0;
        do_timeout = 1'b0;
        do_capture = 1'b0;
        do_finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    do_latch   = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // A master that has left IDLE wins over a simultaneous timeout
                if (bus.m_istate != MST_IDLE) begin
                    do_started = 1'b1;
                    state_next = ST_XFER;
                end else if (cnt == CNT_LAST) begin
                    do_timeout = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    do_inc = 1'b1;
                end
            end
            ST_XFER: begin
                if (bus.m_istate == MST_IDLE) begin
                    do_capture = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                do_finish  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt            <= '0;
            win            <= '0;
            ptr            <= 2'd3;
            cnt            <= '0;
            err_r          <= 1'b0;
            rdata          <= '0;
            bus.m_enable   <= 1'b0;
            bus.m_rw       <= 1'b0;
            bus.m_da       <= 1'b0;
            bus.m_rep      <= 1'b0;
            bus.m_bytcount <= '0;
            bus.m_addr     <= '0;
            bus.m_din      <= '0;
        end else begin
            if (do_latch) begin
                gnt            <= pick;
                win            <= pick_idx;
                cnt            <= '0;
                bus.m_enable   <= 1'b1;
                bus.m_rw       <= req_rw[pick_idx];
                bus.m_da       <= req_da[pick_idx];
                bus.m_rep      <= req_rep[pick_idx];
                bus.m_bytcount <= req_bytcount[2*int'(pick_idx) +: 2];
                bus.m_addr     <= req_addr[7*int'(pick_idx) +: 7];
                bus.m_din      <= req_din[32*int'(pick_idx) +: 32];
            end
            if (do_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (do_started) begin
                bus.m_enable <= 1'b0;
            end
            if (do_timeout) begin
                bus.m_enable <= 1'b0;
                err_r        <= 1'b1;
            end
            if (do_capture) begin
                rdata <= bus.m_dout;
                err_r <= 1'b0;
            end
            if (do_finish) begin
                ptr <= win;
                gnt <= '0;
            end
        end
    end

    // done/err are decoded from RESP so they last exactly one cycle
    always_comb begin
        done = '0;
        err  = 1'b0;
        if (state == ST_RESP) begin
            done = gnt;
            err  = err_r;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
